// File: rtl/ysyx_22041752_dcache_pkg.sv
// Shared widths, request-bus layout and compare-stage FSM states for the D-cache.
package ysyx_22041752_dcache_pkg;

    localparam int ADDR_WD    = 32;
    localparam int DATA_WD    = 64;
    localparam int INDEX_WD   = 6;
    localparam int OFFSET_WD  = 4;
    localparam int TAG_WD     = ADDR_WD - INDEX_WD - OFFSET_WD;
    localparam int TAGV_WD    = TAG_WD + 1;
    localparam int WEN_WD     = 8;
    localparam int BANK_EN_WD = 4;
    localparam int RS_BUS_WD  = ADDR_WD + DATA_WD + WEN_WD + BANK_EN_WD;
    localparam int SETS       = 1 << INDEX_WD;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        REFILL_REQ,
        REFILL
    } state_e;

    function automatic logic [DATA_WD-1:0] merge_bytes(
        input logic [DATA_WD-1:0] old_w,
        input logic [DATA_WD-1:0] new_w,
        input logic [WEN_WD-1:0]  wen
    );
        logic [DATA_WD-1:0] res;
        for (int unsigned i = 0; i < WEN_WD; i++) begin
            res[i*8 +: 8] = wen[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22041752_dcache_meta.sv
// Per-set dirty bits (one per way) and LRU bit; LRU names the way to evict next.
module ysyx_22041752_dcache_meta
    import ysyx_22041752_dcache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_WD-1:0] index,
    output logic [1:0]          dirty_rd,
    output logic                lru_rd,
    input  logic                dirty_we,
    input  logic                dirty_way,
    input  logic                dirty_wval,
    input  logic                lru_we,
    input  logic                lru_wval
);

    logic [SETS-1:0] dirty0_q, dirty0_d;
    logic [SETS-1:0] dirty1_q, dirty1_d;
    logic [SETS-1:0] lru_q, lru_d;

    always_comb begin
        dirty0_d = dirty0_q;
        dirty1_d = dirty1_q;
        lru_d    = lru_q;
        if (dirty_we) begin
            if (dirty_way) dirty1_d[index] = dirty_wval;
            else           dirty0_d[index] = dirty_wval;
        end
        if (lru_we) lru_d[index] = lru_wval;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dirty0_q <= '0;
            dirty1_q <= '0;
            lru_q    <= '0;
        end else begin
            dirty0_q <= dirty0_d;
            dirty1_q <= dirty1_d;
            lru_q    <= lru_d;
        end
    end

    assign dirty_rd = {dirty1_q[index], dirty0_q[index]};
    assign lru_rd   = lru_q[index];

endmodule

// File: rtl/ysyx_22041752_dcache_cmp.sv
// D-cache compare/miss stage: tag check, hit service, dirty victim writeback and line refill.
module ysyx_22041752_dcache_cmp
    import ysyx_22041752_dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rs_to_cs_valid,
    input  logic [RS_BUS_WD-1:0]   rs_to_cs_bus,
    output logic                   cmp_allowin,
    input  logic [2*TAGV_WD-1:0]   tagv_rdata,
    input  logic [4*DATA_WD-1:0]   bank_rdata,
    output logic [1:0]             tagv_we,
    output logic [TAGV_WD-1:0]     tagv_wdata,
    output logic [4*WEN_WD-1:0]    bank_we,
    output logic [DATA_WD-1:0]     bank_wdata,
    output logic [INDEX_WD-1:0]    waddr,
    output logic                   data_ok,
    output logic [DATA_WD-1:0]     data_rdata,
    output logic                   rd_req,
    input  logic                   rd_rdy,
    output logic [ADDR_WD-1:0]     rd_addr,
    input  logic                   ret_valid,
    input  logic                   ret_last,
    input  logic [DATA_WD-1:0]     ret_data,
    output logic                   wr_req,
    input  logic                   wr_rdy,
    output logic [ADDR_WD-1:0]     wr_addr,
    output logic [2*DATA_WD-1:0]   wr_data
);

    state_e                 state_q, state_d;
    logic [ADDR_WD-1:0]     req_addr_q, req_addr_d;
    logic [DATA_WD-1:0]     req_wdata_q, req_wdata_d;
    logic [WEN_WD-1:0]      req_wen_q, req_wen_d;
    logic                   vic_way_q, vic_way_d;
    logic                   vic_dirty_q, vic_dirty_d;
    logic [TAGV_WD-1:0]     vic_tagv_q, vic_tagv_d;
    logic [2*DATA_WD-1:0]   vic_line_q, vic_line_d;
    logic                   beat_q, beat_d;
    logic [DATA_WD-1:0]     tgt_word_q, tgt_word_d;

    logic [ADDR_WD-1:0]     rs_addr;
    logic [DATA_WD-1:0]     rs_wdata;
    logic [WEN_WD-1:0]      rs_wen;
    logic [BANK_EN_WD-1:0]  rs_bank_en;
    logic [TAG_WD-1:0]      req_tag;
    logic [INDEX_WD-1:0]    req_index;
    logic                   req_word, req_store;
    logic [TAGV_WD-1:0]     tagv_way0, tagv_way1;
    logic                   hit0, hit1, hit, hit_way, accept;
    logic [1:0]             hit_bank, refill_bank;
    logic [1:0]             dirty_rd;
    logic                   lru_rd, dirty_we, dirty_way, dirty_wval, lru_we, lru_wval;
    logic                   unused_bits;

    assign rs_addr    = rs_to_cs_bus[RS_BUS_WD-1 -: ADDR_WD];
    assign rs_wdata   = rs_to_cs_bus[WEN_WD+BANK_EN_WD +: DATA_WD];
    assign rs_wen     = rs_to_cs_bus[BANK_EN_WD +: WEN_WD];
    assign rs_bank_en = rs_to_cs_bus[0 +: BANK_EN_WD];
    assign unused_bits = ^{rs_bank_en, req_addr_q[2:0]};

    assign req_tag   = req_addr_q[ADDR_WD-1 -: TAG_WD];
    assign req_index = req_addr_q[OFFSET_WD +: INDEX_WD];
    assign req_word  = req_addr_q[3];
    assign req_store = |req_wen_q;

    assign tagv_way0 = tagv_rdata[0 +: TAGV_WD];
    assign tagv_way1 = tagv_rdata[TAGV_WD +: TAGV_WD];
    assign hit0      = tagv_way0[TAG_WD] && (tagv_way0[TAG_WD-1:0] == req_tag);
    assign hit1      = tagv_way1[TAG_WD] && (tagv_way1[TAG_WD-1:0] == req_tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = hit1;
    assign hit_bank    = {hit_way, req_word};
    assign refill_bank = {vic_way_q, beat_q};

    // A store hit writes the banks in LOOKUP, so no new read may start that cycle.
    assign cmp_allowin = reset || (state_q == IDLE) || (state_q == LOOKUP && hit && !req_store);
    assign accept      = rs_to_cs_valid && cmp_allowin;

    assign rd_addr = {req_addr_q[ADDR_WD-1:OFFSET_WD], {OFFSET_WD{1'b0}}};
    assign wr_addr = {vic_tagv_q[TAG_WD-1:0], req_index, {OFFSET_WD{1'b0}}};
    assign wr_data = vic_line_q;
    assign waddr   = req_index;

    ysyx_22041752_dcache_meta u_meta (
        .clk        (clk),
        .reset      (reset),
        .index      (req_index),
        .dirty_rd   (dirty_rd),
        .lru_rd     (lru_rd),
        .dirty_we   (dirty_we),
        .dirty_way  (dirty_way),
        .dirty_wval (dirty_wval),
        .lru_we     (lru_we),
        .lru_wval   (lru_wval)
    );

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wen_d   = req_wen_q;
        vic_way_d   = vic_way_q;
        vic_dirty_d = vic_dirty_q;
        vic_tagv_d  = vic_tagv_q;
        vic_line_d  = vic_line_q;
        beat_d      = beat_q;
        tgt_word_d  = tgt_word_q;
        tagv_we     = '0;
        tagv_wdata  = '0;
        bank_we     = '0;
        bank_wdata  = '0;
        data_ok     = 1'b0;
        data_rdata  = '0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        dirty_we    = 1'b0;
        dirty_way   = 1'b0;
        dirty_wval  = 1'b0;
        lru_we      = 1'b0;
        lru_wval    = 1'b0;

        unique case (state_q)
            IDLE: ;
            LOOKUP: begin
                if (hit) begin
                    data_ok  = 1'b1;
                    lru_we   = 1'b1;
                    lru_wval = ~hit_way;
                    if (req_store) begin
                        bank_we[hit_bank*WEN_WD +: WEN_WD] = req_wen_q;
                        bank_wdata = req_wdata_q;
                        dirty_we   = 1'b1;
                        dirty_way  = hit_way;
                        dirty_wval = 1'b1;
                    end else begin
                        data_rdata = bank_rdata[hit_bank*DATA_WD +: DATA_WD];
                    end
                    state_d = IDLE;
                end else begin
                    vic_way_d   = lru_rd;
                    vic_dirty_d = dirty_rd[lru_rd];
                    vic_tagv_d  = lru_rd ? tagv_way1 : tagv_way0;
                    vic_line_d  = bank_rdata[lru_rd*2*DATA_WD +: 2*DATA_WD];
                    state_d     = MISS;
                end
            end
            MISS: begin
                if (vic_tagv_q[TAG_WD] && vic_dirty_q) begin
                    wr_req = 1'b1;
                    if (wr_rdy) begin
                        dirty_we  = 1'b1;
                        dirty_way = vic_way_q;
                        state_d   = REFILL_REQ;
                    end
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                rd_req = 1'b1;
                if (rd_rdy) begin
                    beat_d  = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (ret_valid) begin
                    bank_we[refill_bank*WEN_WD +: WEN_WD] = '1;
                    bank_wdata = (req_store && beat_q == req_word) ?
                                 merge_bytes(ret_data, req_wdata_q, req_wen_q) : ret_data;
                    beat_d = ~beat_q;
                    if (beat_q == req_word) tgt_word_d = ret_data;
                    if (ret_last) begin
                        tagv_we[vic_way_q] = 1'b1;
                        tagv_wdata = {1'b1, req_tag};
                        dirty_we   = 1'b1;
                        dirty_way  = vic_way_q;
                        dirty_wval = req_store;
                        lru_we     = 1'b1;
                        lru_wval   = ~vic_way_q;
                        data_ok    = 1'b1;
                        if (!req_store) data_rdata = (beat_q == req_word) ? ret_data : tgt_word_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_addr_d  = rs_addr;
            req_wdata_d = rs_wdata;
            req_wen_d   = rs_wen;
            state_d     = LOOKUP;
        end

        // Reset must silence handshakes and SRAM writes in the very cycle it is asserted.
        if (reset) begin
            tagv_we  = '0;
            bank_we  = '0;
            data_ok  = 1'b0;
            rd_req   = 1'b0;
            wr_req   = 1'b0;
            dirty_we = 1'b0;
            lru_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wen_q   <= '0;
            vic_way_q   <= 1'b0;
            vic_dirty_q <= 1'b0;
            vic_tagv_q  <= '0;
            vic_line_q  <= '0;
            beat_q      <= 1'b0;
            tgt_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wen_q   <= req_wen_d;
            vic_way_q   <= vic_way_d;
            vic_dirty_q <= vic_dirty_d;
            vic_tagv_q  <= vic_tagv_d;
            vic_line_q  <= vic_line_d;
            beat_q      <= beat_d;
            tgt_word_q  <= tgt_word_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_dcache_cmp.sv
// Directed bench for the D-cache compare stage with behavioural tag/data SRAMs and memory side.
module tb_ysyx_22041752_dcache_cmp;

    logic          clk = 1'b0;
    logic          reset;
    logic          rs_valid;
    logic [31:0]   rs_addr;
    logic [63:0]   rs_wdata;
    logic [7:0]    rs_wen;
    logic [107:0]  rs_bus;
    logic          cmp_allowin;
    logic [45:0]   tagv_rdata;
    logic [255:0]  bank_rdata;
    logic [1:0]    tagv_we;
    logic [22:0]   tagv_wdata;
    logic [31:0]   bank_we;
    logic [63:0]   bank_wdata;
    logic [5:0]    waddr;
    logic          data_ok;
    logic [63:0]   data_rdata;
    logic          rd_req, rd_rdy;
    logic [31:0]   rd_addr;
    logic          ret_valid, ret_last;
    logic [63:0]   ret_data;
    logic          wr_req, wr_rdy;
    logic [31:0]   wr_addr;
    logic [127:0]  wr_data;
    logic          mem_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rs_bus = {rs_addr, rs_wdata, rs_wen, 4'b0000};

    ysyx_22041752_dcache_cmp dut (
        .clk            (clk),
        .reset          (reset),
        .rs_to_cs_valid (rs_valid),
        .rs_to_cs_bus   (rs_bus),
        .cmp_allowin    (cmp_allowin),
        .tagv_rdata     (tagv_rdata),
        .bank_rdata     (bank_rdata),
        .tagv_we        (tagv_we),
        .tagv_wdata     (tagv_wdata),
        .bank_we        (bank_we),
        .bank_wdata     (bank_wdata),
        .waddr          (waddr),
        .data_ok        (data_ok),
        .data_rdata     (data_rdata),
        .rd_req         (rd_req),
        .rd_rdy         (rd_rdy),
        .rd_addr        (rd_addr),
        .ret_valid      (ret_valid),
        .ret_last       (ret_last),
        .ret_data       (ret_data),
        .wr_req         (wr_req),
        .wr_rdy         (wr_rdy),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    // Behavioural SRAMs: index registered on accept, contents not cleared by DUT reset.
    logic [22:0] m_tagv [2][64];
    logic [63:0] m_bank [4][64];
    logic [5:0]  rd_idx = 6'd0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) begin
                for (int w = 0; w < 2; w++) m_tagv[w][i] <= '0;
                for (int b = 0; b < 4; b++) m_bank[b][i] <= '0;
            end
        end else begin
            for (int w = 0; w < 2; w++)
                if (tagv_we[w]) m_tagv[w][waddr] <= tagv_wdata;
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < 8; k++)
                    if (bank_we[b*8+k]) m_bank[b][waddr][k*8 +: 8] <= bank_wdata[k*8 +: 8];
        end
        if (rs_valid && cmp_allowin) rd_idx <= rs_addr[9:4];
    end

    assign tagv_rdata = {m_tagv[1][rd_idx], m_tagv[0][rd_idx]};
    assign bank_rdata = {m_bank[3][rd_idx], m_bank[2][rd_idx], m_bank[1][rd_idx], m_bank[0][rd_idx]};

    // Monitor samples mid-way between the input-drive edge and the active edge.
    int           ok_cnt = 0, wr_cnt = 0, rd_cnt = 0, tagv_cnt = 0, rd_at_wr = 0;
    logic [63:0]  ok_data [64];
    logic [63:0]  last_rdata = '0;
    logic [31:0]  last_rd_addr = '0, last_wr_addr = '0, last_bank_we = '0;
    logic [63:0]  last_bank_wdata = '0;
    logic [127:0] last_wr_data = '0;
    logic [1:0]   last_tagv_we = '0;

    always begin
        @(negedge clk);
        #3;
        if (data_ok) begin
            ok_data[ok_cnt % 64] = data_rdata;
            last_rdata = data_rdata;
            ok_cnt++;
        end
        if (wr_req) begin
            wr_cnt++;
            rd_at_wr = rd_cnt;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (rd_req) begin
            rd_cnt++;
            last_rd_addr = rd_addr;
        end
        if (|tagv_we) begin
            tagv_cnt++;
            last_tagv_we = tagv_we;
        end
        if (|bank_we) begin
            last_bank_we = bank_we;
            last_bank_wdata = bank_wdata;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Presents one request; returns after the LOOKUP cycle has been sampled.
    task automatic issue(input logic [31:0] a, input logic [63:0] d, input logic [7:0] we);
        @(negedge clk);
        rs_valid = 1'b1; rs_addr = a; rs_wdata = d; rs_wen = we;
        #1 check("allowin_on_issue", cmp_allowin, 1);
        @(negedge clk);
        rs_valid = 1'b0; rs_wen = '0;
        #4;
    endtask

    // Acks any writeback, then the refill request, then returns two beats.
    task automatic serve(input logic [63:0] w0, input logic [63:0] w1);
        int n;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            wr_rdy = 1'b0; rd_rdy = 1'b0;
            #1;
            if (wr_req) wr_rdy = 1'b1;
            else if (rd_req) begin
                rd_rdy = 1'b1;
                break;
            end
        end
        if (n >= 30) check("refill_timeout", n, 0);
        @(negedge clk);
        rd_rdy = 1'b0; wr_rdy = 1'b0;
        ret_valid = 1'b1; ret_last = 1'b0; ret_data = w0;
        @(negedge clk);
        ret_last = 1'b1; ret_data = w1;
        @(negedge clk);
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        #4;
    endtask

    localparam logic [63:0] A = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] B = 64'hfedc_ba98_7654_3210;
    localparam logic [63:0] C = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D = 64'h5555_6666_7777_8888;
    localparam logic [63:0] E = 64'h9999_aaaa_bbbb_cccc;
    localparam logic [63:0] F = 64'hdddd_eeee_ffff_0000;
    localparam logic [63:0] G = 64'h0bad_0bad_0bad_0bad;
    localparam logic [63:0] H = 64'h1234_5678_9abc_def0;
    localparam logic [63:0] I = 64'h0fed_cba9_8765_4321;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_ok, s_wr, s_rd, s_tv, n;
        reset = 1'b1; mem_clear = 1'b1;
        rs_valid = 1'b0; rs_addr = '0; rs_wdata = '0; rs_wen = '0;
        rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_allowin", cmp_allowin, 1);
        check("rst_outputs", {data_ok, rd_req, wr_req, tagv_we, bank_we}, 0);
        check("rst_data", {data_rdata, rd_addr, wr_addr}, 0);
        @(negedge clk);
        reset = 1'b0; mem_clear = 1'b0;

        // 1: cold load miss, refill into way0
        s_ok = ok_cnt; s_wr = wr_cnt;
        issue(32'h8000_0010, '0, '0);
        check("t1_lookup_no_ok", ok_cnt - s_ok, 0);
        serve(A, B);
        check("t1_rd_addr", last_rd_addr, 32'h8000_0010);
        check("t1_ok_cnt", ok_cnt - s_ok, 1);
        check("t1_rdata", last_rdata, A);
        check("t1_tagv_we", last_tagv_we, 2'b01);
        check("t1_no_wr", wr_cnt - s_wr, 0);

        // 2: load hit on the other word
        s_ok = ok_cnt; s_rd = rd_cnt;
        issue(32'h8000_0018, '0, '0);
        check("t2_ok_in_lookup", ok_cnt - s_ok, 1);
        check("t2_rdata", last_rdata, B);
        check("t2_allowin_hit", cmp_allowin, 1);
        check("t2_no_rd", rd_cnt - s_rd, 0);

        // 3: store hit, then read back the merged word
        s_ok = ok_cnt;
        issue(32'h8000_0010, 64'h0000_0000_1122_3344, 8'h0F);
        check("t3_store_ok", ok_cnt - s_ok, 1);
        check("t3_allowin_store", cmp_allowin, 0);
        check("t3_bank_we", last_bank_we, 32'h0000_000F);
        check("t3_bank_wdata", last_bank_wdata[31:0], 32'h1122_3344);
        issue(32'h8000_0010, '0, '0);
        check("t3_merged", last_rdata, 64'h0123_4567_1122_3344);

        // 4: fill way1, then a third tag evicts dirty way0
        s_wr = wr_cnt;
        issue(32'h8000_0410, '0, '0);
        serve(C, D);
        check("t4_fill_rdata", last_rdata, C);
        check("t4_fill_tagv_we", last_tagv_we, 2'b10);
        check("t4_fill_no_wr", wr_cnt - s_wr, 0);
        s_wr = wr_cnt; s_rd = rd_cnt;
        issue(32'h8000_0810, '0, '0);
        serve(E, F);
        check("t4_wr_seen", wr_cnt != s_wr, 1);
        check("t4_wr_before_rd", rd_at_wr, s_rd);
        check("t4_wr_addr", last_wr_addr, 32'h8000_0010);
        check("t4_wr_data", last_wr_data, {B, 64'h0123_4567_1122_3344});
        check("t4_rd_cycles", rd_cnt - s_rd, 1);
        check("t4_rdata", last_rdata, E);
        check("t4_tagv_we", last_tagv_we, 2'b01);

        // 5: back-to-back load hits
        s_ok = ok_cnt;
        @(negedge clk);
        rs_valid = 1'b1; rs_addr = 32'h8000_0810; rs_wen = '0;
        #1 check("t5_allowin0", cmp_allowin, 1);
        @(negedge clk);
        rs_addr = 32'h8000_0418;
        #1 check("t5_allowin1", cmp_allowin, 1);
        @(negedge clk);
        rs_addr = 32'h8000_0818;
        #1 check("t5_allowin2", cmp_allowin, 1);
        @(negedge clk);
        rs_valid = 1'b0;
        #4;
        check("t5_ok_cnt", ok_cnt - s_ok, 3);
        check("t5_rdata0", ok_data[s_ok % 64], E);
        check("t5_rdata1", ok_data[(s_ok + 1) % 64], D);
        check("t5_rdata2", ok_data[(s_ok + 2) % 64], F);

        // 6: reset while in REFILL
        s_tv = tagv_cnt;
        issue(32'h8000_0C10, '0, '0);
        for (n = 0; n < 30 && !rd_req; n++) begin
            @(negedge clk);
            #1;
        end
        check("t6_rd_req", rd_req, 1);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_data = G; reset = 1'b1;
        #1;
        check("t6_rst_no_bank_we", bank_we, 0);
        check("t6_rst_no_ok", data_ok, 0);
        @(negedge clk);
        reset = 1'b0; ret_valid = 1'b0; ret_data = '0;
        #1;
        check("t6_allowin", cmp_allowin, 1);
        check("t6_reqs_dropped", {rd_req, wr_req}, 0);
        check("t6_no_tagv_we", tagv_cnt - s_tv, 0);
        s_ok = ok_cnt; s_rd = rd_cnt; s_wr = wr_cnt;
        issue(32'h8000_0C10, '0, '0);
        check("t6_misses_again", ok_cnt - s_ok, 0);
        serve(H, I);
        check("t6_refetch", rd_cnt - s_rd, 1);
        check("t6_no_wr", wr_cnt - s_wr, 0);
        check("t6_rdata", last_rdata, H);
        check("t6_lru_cleared", last_tagv_we, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
